// File: rtl/multicycle_controller.sv
// Multicycle MIPS control FSM: sequences IF/ID/EX/MEM/WB over a shared memory port and ALU.
// Optional performance counters (cycle_cnt, instr_cnt) are enabled by defining MC_PERF_CNT_EN.
module multicycle_controller #(
  parameter int unsigned RA_REG = 31
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  OpCode,
  input  logic [5:0]  Funct,
  input  logic        Zero,
  input  logic        mem_ready,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic [1:0]  RegDst,
  output logic [1:0]  MemtoReg,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  PCSource,
  output logic [4:0]  ra_idx,
  output logic [2:0]  state,
  output logic        illegal
`ifdef MC_PERF_CNT_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instr_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;

  state_t state_reg;
  state_t state_next;

  logic is_rtype, is_j, is_jal, is_beq, is_lw, is_sw, is_itype;
  logic is_jr, is_jalr, is_shift, is_supported, is_jump;

  // The branch condition is applied outside the FSM via PCWriteCond.
  logic unused_zero;
  assign unused_zero = Zero;

  // Opcode / function decode
  always_comb begin
    is_rtype     = (OpCode == OP_RTYPE);
    is_j         = (OpCode == OP_J);
    is_jal       = (OpCode == OP_JAL);
    is_beq       = (OpCode == OP_BEQ);
    is_lw        = (OpCode == OP_LW);
    is_sw        = (OpCode == OP_SW);
    is_itype     = (OpCode == OP_ADDI)  || (OpCode == OP_ADDIU) ||
                   (OpCode == OP_SLTI)  || (OpCode == OP_SLTIU) ||
                   (OpCode == OP_ANDI)  || (OpCode == OP_LUI);
    is_jr        = is_rtype && (Funct == FN_JR);
    is_jalr      = is_rtype && (Funct == FN_JALR);
    is_shift     = is_rtype && ((Funct == FN_SLL) || (Funct == FN_SRL) || (Funct == FN_SRA));
    is_supported = is_rtype || is_j || is_jal || is_beq || is_lw || is_sw || is_itype;
    is_jump      = is_j || is_jal || is_jr || is_jalr;
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= S_IF;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IF: begin
        if (mem_ready) state_next = S_ID;
      end
      S_ID: begin
        if (!is_supported || is_jump) state_next = S_IF;
        else                          state_next = S_EX;
      end
      S_EX: begin
        if (is_beq)             state_next = S_IF;
        else if (is_lw || is_sw) state_next = S_MEM;
        else                    state_next = S_WB;
      end
      S_MEM: begin
        if (mem_ready) state_next = is_lw ? S_WB : S_IF;
      end
      S_WB:    state_next = S_IF;
      default: state_next = S_IF;
    endcase
  end

  // Output logic; everything is forced low while reset is held.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 2'b00;
    MemtoReg    = 2'b00;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    PCSource    = 2'b00;
    illegal     = 1'b0;
    if (reset) begin
      case (state_reg)
        S_IF: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          if (mem_ready) begin
            IRWrite = 1'b1;
            PCWrite = 1'b1;
          end
        end
        S_ID: begin
          ALUSrcB = 2'b11;
          if (!is_supported) begin
            illegal = 1'b1;
          end else if (is_j || is_jal) begin
            PCSource = 2'b10;
            PCWrite  = 1'b1;
          end else if (is_jr || is_jalr) begin
            PCSource = 2'b11;
            PCWrite  = 1'b1;
          end
          if (is_jal || is_jalr) begin
            RegWrite = 1'b1;
            RegDst   = 2'b10;
            MemtoReg = 2'b10;
          end
        end
        S_EX: begin
          if (is_beq) begin
            ALUSrcA     = 2'b01;
            ALUSrcB     = 2'b00;
            PCSource    = 2'b01;
            PCWriteCond = 1'b1;
          end else if (is_shift) begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b00;
          end else if (is_rtype) begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b00;
          end else begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b10;
          end
        end
        S_MEM: begin
          IorD     = 1'b1;
          MemRead  = is_lw;
          MemWrite = is_sw;
        end
        S_WB: begin
          RegWrite = 1'b1;
          if (is_lw) begin
            MemtoReg = 2'b01;
            RegDst   = 2'b00;
          end else if (is_rtype) begin
            MemtoReg = 2'b00;
            RegDst   = 2'b01;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign state  = state_reg;
  assign ra_idx = 5'(RA_REG);

`ifdef MC_PERF_CNT_EN
  logic [31:0] cycle_cnt_reg;
  logic [31:0] instr_cnt_reg;

  // An instruction retires whenever the FSM re-enters IF from any other phase.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_cnt_reg <= 32'd0;
      instr_cnt_reg <= 32'd0;
    end else begin
      cycle_cnt_reg <= cycle_cnt_reg + 32'd1;
      if ((state_reg != S_IF) && (state_next == S_IF)) begin
        instr_cnt_reg <= instr_cnt_reg + 32'd1;
      end
    end
  end

  assign cycle_cnt = cycle_cnt_reg;
  assign instr_cnt = instr_cnt_reg;
`endif

endmodule
